sd_sector_streamer: RTL and testbench
=====================================

Name: sd_sector_streamer

Overview:
- Sequences the SD SPI read engine to stream a contiguous run of sectors (e.g. one stored image frame) into a downstream pixel FIFO.
- Issues one single-sector read at a time and auto-increments the sector address.
- Gates each read on FIFO free space, because the SD read path cannot be stalled mid-sector.
- Checks word counts and timeouts, and optionally loops the run continuously for display refresh.

Parameters:
- SEC_WORDS, 256, 16-bit words per 512-byte sector.
- TO_CYCLES, 1000000, maximum clk_ref cycles allowed in WAIT_BUSY or XFER before error.
- CNT_W, 16, width of the sector-count input and counters.

Ports:
- clk_ref  in  1  system clock, the same clock as the SD controller.
- rst  in  1  asynchronous reset, active-high.
- sd_init_done  in  1  SD card initialised.
- start  in  1  single-cycle pulse; begins a run.
- abort  in  1  single-cycle pulse; stops at the next sector boundary.
- base_sec  in  32  first sector address, sampled on start.
- num_secs  in  CNT_W  sectors per run, sampled on start; 0 is illegal.
- loop_en  in  1  restart from base_sec after the last sector; sampled continuously.
- rd_start_en  out  1  single-cycle read request to the SD controller.
- rd_sec_addr  out  32  sector address, held stable from request until rd_busy falls.
- rd_busy  in  1  SD read in progress.
- rd_val_en  in  1  rd_val_data valid.
- rd_val_data  in  16  read word.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  16  FIFO write data.
- fifo_free  in  CNT_W  free FIFO words.
- busy  out  1  run active.
- done  out  1  single-cycle pulse when a non-looping run ends cleanly or abort completes.
- err  out  1  sticky; cleared by the next start.
- err_code  out  2  error cause: 0 none, 1 timeout, 2 word-count mismatch, 3 num_secs==0.
- sec_idx  out  CNT_W  index of the current sector within the run.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- FSM states: IDLE, WAIT_INIT, CHK_ROOM, ISSUE, WAIT_BUSY, XFER, NEXT, ERR.
- IDLE:
  - start with num_secs==0 -> ERR with code 3.
  - Any other start -> latch base_sec/num_secs, clear err, sec_idx=0, addr=base_sec, go to WAIT_INIT.
  - start is ignored while busy.
- WAIT_INIT: wait for sd_init_done=1 (no timeout), then go to CHK_ROOM.
- CHK_ROOM: stay until fifo_free >= SEC_WORDS; abort pending -> IDLE with done.
- ISSUE: rd_start_en=1 for exactly one cycle, rd_sec_addr=addr; go to WAIT_BUSY.
- WAIT_BUSY: wait for rd_busy=1; on rd_busy=1 clear word_cnt and go to XFER.
- XFER:
  - Each rd_val_en -> fifo_wr_en=1 with fifo_wr_data=rd_val_data, registered (1-cycle latency), and word_cnt+1.
  - Words arriving outside XFER are dropped.
  - On rd_busy 1->0: word_cnt!=SEC_WORDS -> ERR with code 2; otherwise go to NEXT.
  - A final rd_val_en in the same cycle as the rd_busy fall is counted.
- NEXT:
  - Pending abort -> IDLE with done.
  - Not the last sector (sec_idx < num_secs-1) -> sec_idx+1, addr+1 (32-bit wrap allowed), go to CHK_ROOM.
  - Last sector with loop_en=1 -> sec_idx=0, addr=base_sec, go to CHK_ROOM.
  - Last sector with loop_en=0 -> done, go to IDLE.
- Timeout counter: reset on every state entry and runs only in WAIT_BUSY and XFER; reaching TO_CYCLES -> ERR with code 1.
- ERR: err=1, busy=0, no done pulse; leaves on start, handled exactly as from IDLE.
- busy=1 in every state except IDLE and ERR.
- abort: latched as pending and never interrupts a sector in flight.
- sd_init_done falling mid-run: ignored inside XFER (the timeout covers it); CHK_ROOM and NEXT go back to WAIT_INIT.
- rst mid-transfer: FSM returns to IDLE immediately; the SD controller completes or is reset separately.

Decomposition:
- Shared package sd_pkg holds:
  - State enum.
  - err_code constants: ERR_NONE, ERR_TO, ERR_CNT, ERR_ZERO.
  - SD_SEC_WORDS=256.
- Optional sub-module sd_timeout_cnt: load/enable counter with an expired flag.
- The rest is a single FSM with counters.

Test Plan:
- base_sec=0x1000, num_secs=3, fifo_free=1024, SD model delivers 256 words per sector -> three rd_start_en pulses at addresses 0x1000, 0x1001, 0x1002; 768 fifo_wr_en; one done pulse; err=0.
- fifo_free=200 for 50 cycles, then 256 -> no rd_start_en while free is below 256; request issued within 2 cycles of free reaching 256.
- SD model returns 255 words -> err=1 with err_code=2; busy=0; no further rd_start_en.
- SD model never asserts rd_busy, TO_CYCLES=100 -> err_code=1 after 100 cycles in WAIT_BUSY.
- loop_en=1, num_secs=2, base=0xFFFFFFFF -> address sequence FFFFFFFF, 00000000, FFFFFFFF, ...; abort during the 3rd sector -> that sector completes, then done with no further request.
- start with num_secs=0 -> err_code=3; rst asserted mid-XFER -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD sector streamer.
package sd_pkg;
    localparam int SD_SEC_WORDS = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_CHK_ROOM,
        S_ISSUE,
        S_WAIT_BUSY,
        S_XFER,
        S_NEXT,
        S_ERR
    } sd_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_TO   = 2'd1;
    localparam logic [1:0] ERR_CNT  = 2'd2;
    localparam logic [1:0] ERR_ZERO = 2'd3;
endpackage

// File: rtl/sd_sector_streamer_if.sv
// SD read-engine request/data bus plus the downstream pixel FIFO write port.
interface sd_sector_streamer_if #(parameter int CNT_W = 16);
    logic             rd_start_en;
    logic [31:0]      rd_sec_addr;
    logic             rd_busy;
    logic             rd_val_en;
    logic [15:0]      rd_val_data;
    logic             fifo_wr_en;
    logic [15:0]      fifo_wr_data;
    logic [CNT_W-1:0] fifo_free;

    modport master (
        output rd_start_en, rd_sec_addr, fifo_wr_en, fifo_wr_data,
        input  rd_busy, rd_val_en, rd_val_data, fifo_free
    );

    modport slave (
        input  rd_start_en, rd_sec_addr, fifo_wr_en, fifo_wr_data,
        output rd_busy, rd_val_en, rd_val_data, fifo_free
    );
endinterface

// File: rtl/sd_timeout_cnt.sv
// Watchdog counter: cleared by load, counts while enabled, flags the last allowed cycle.
// Latency: expired is combinational on the TO_CYCLES-th enabled cycle after load.
// Backpressure: none; holds its count once expired until the next load.
module sd_timeout_cnt #(
    parameter int TO_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TO_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TO_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == LAST);
endmodule

// File: rtl/sd_sector_streamer.sv
// Streams a run of sectors from the SD SPI read engine into the pixel FIFO, one read at a time.
// Latency: FIFO write is one clk_ref after each rd_val_en; a read issues 1 cycle after room is seen.
// Backpressure: a read is only issued with a full sector of FIFO room; the sector itself is never stalled.
module sd_sector_streamer
    import sd_pkg::*;
#(
    parameter int SEC_WORDS = SD_SEC_WORDS,
    parameter int TO_CYCLES = 1000000,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_ref,
    input  logic                 rst,
    input  logic                 sd_init_done,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          base_sec,
    input  logic [CNT_W-1:0]     num_secs,
    input  logic                 loop_en,
    sd_sector_streamer_if.master sd,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [CNT_W-1:0]     sec_idx
);
    localparam logic [CNT_W-1:0] SEC_WORDS_C = CNT_W'(SEC_WORDS);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    sd_state_t        state, nxt;
    logic [31:0]      base_q, addr_q;
    logic [CNT_W-1:0] num_q, idx_q, word_cnt, final_cnt;
    logic             abort_pend, done_q, wr_en_q;
    logic [15:0]      wr_data_q;
    logic [1:0]       code_q;
    logic             to_expired, start_ok, start_zero, last_sec, take_word;

    assign start_ok   = start && (state == S_IDLE || state == S_ERR);
    assign start_zero = start_ok && (num_secs == '0);
    assign last_sec   = (idx_q == num_q - ONE_C);
    assign take_word  = (state == S_XFER) && sd.rd_val_en;
    // A word arriving together with the rd_busy fall still belongs to this sector.
    assign final_cnt  = word_cnt + CNT_W'(sd.rd_val_en);

    sd_timeout_cnt #(.TO_CYCLES(TO_CYCLES)) u_to (
        .clk     (clk_ref),
        .rst     (rst),
        .load    (nxt != state),
        .en      (state == S_WAIT_BUSY || state == S_XFER),
        .expired (to_expired)
    );

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_ERR: if (start_ok) nxt = start_zero ? S_ERR : S_WAIT_INIT;
            S_WAIT_INIT:   if (sd_init_done) nxt = S_CHK_ROOM;
            S_CHK_ROOM: begin
                if (abort_pend)                         nxt = S_IDLE;
                else if (!sd_init_done)                 nxt = S_WAIT_INIT;
                else if (sd.fifo_free >= SEC_WORDS_C)   nxt = S_ISSUE;
            end
            S_ISSUE:       nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (sd.rd_busy)       nxt = S_XFER;
                else if (to_expired)  nxt = S_ERR;
            end
            S_XFER: begin
                if (!sd.rd_busy)      nxt = (final_cnt == SEC_WORDS_C) ? S_NEXT : S_ERR;
                else if (to_expired)  nxt = S_ERR;
            end
            S_NEXT: begin
                if (abort_pend || (last_sec && !loop_en)) nxt = S_IDLE;
                else                                      nxt = sd_init_done ? S_CHK_ROOM : S_WAIT_INIT;
            end
            default:       nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sd.rd_start_en = (state == S_ISSUE);
        busy           = (state != S_IDLE) && (state != S_ERR);
        err            = (state == S_ERR);
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            addr_q     <= '0;
            num_q      <= '0;
            idx_q      <= '0;
            word_cnt   <= '0;
            abort_pend <= 1'b0;
            done_q     <= 1'b0;
            code_q     <= ERR_NONE;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            if (start_ok && !start_zero) begin
                base_q <= base_sec;
                num_q  <= num_secs;
                addr_q <= base_sec;
                idx_q  <= '0;
            end else if (state == S_NEXT && nxt != S_IDLE) begin
                if (last_sec) begin
                    idx_q  <= '0;
                    addr_q <= base_q;
                end else begin
                    idx_q  <= idx_q + ONE_C;
                    addr_q <= addr_q + 32'd1;
                end
            end

            if (state == S_WAIT_BUSY && sd.rd_busy)
                word_cnt <= '0;
            else if (take_word)
                word_cnt <= word_cnt + ONE_C;

            if (start_ok || nxt == S_IDLE)
                abort_pend <= 1'b0;
            else if (abort && busy)
                abort_pend <= 1'b1;

            done_q <= (nxt == S_IDLE) && (state == S_CHK_ROOM || state == S_NEXT);

            if (start_ok)
                code_q <= start_zero ? ERR_ZERO : ERR_NONE;
            else if (nxt == S_ERR && state != S_ERR)
                code_q <= (state == S_XFER && !sd.rd_busy) ? ERR_CNT : ERR_TO;

            wr_en_q <= take_word;
            if (take_word)
                wr_data_q <= sd.rd_val_data;
        end
    end

    assign sd.rd_sec_addr  = addr_q;
    assign sd.fifo_wr_en   = wr_en_q;
    assign sd.fifo_wr_data = wr_data_q;
    assign done            = done_q;
    assign err_code        = code_q;
    assign sec_idx         = idx_q;
endmodule

// File: tb/tb_sd_sector_streamer.sv
// Bench for sd_sector_streamer: table of whole runs plus hand sequences for room/init gating, timeout, loop/abort and reset.
module tb_sd_sector_streamer;
    import sd_pkg::*;

    localparam int CNT_W = 16;
    localparam int TO_C  = 400;

    logic             clk_ref = 1'b0;
    logic             rst = 1'b1;
    logic             sd_init_done, start, abort, loop_en;
    logic [31:0]      base_sec;
    logic [CNT_W-1:0] num_secs;
    logic             busy, done, err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] sec_idx;

    sd_sector_streamer_if #(.CNT_W(CNT_W)) bus ();

    sd_sector_streamer #(.SEC_WORDS(256), .TO_CYCLES(TO_C), .CNT_W(CNT_W)) dut (
        .clk_ref      (clk_ref),
        .rst          (rst),
        .sd_init_done (sd_init_done),
        .start        (start),
        .abort        (abort),
        .base_sec     (base_sec),
        .num_secs     (num_secs),
        .loop_en      (loop_en),
        .sd           (bus),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .sec_idx      (sec_idx)
    );

    always #5 clk_ref = ~clk_ref;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // SD card model: after each request, busy for sd_words words; the last word lands with the busy fall.
    logic        sd_respond;
    int          sd_words;
    logic [31:0] sd_addr;
    initial begin
        bus.rd_busy = 1'b0; bus.rd_val_en = 1'b0; bus.rd_val_data = '0;
        forever begin
            @(negedge clk_ref);
            if (bus.rd_start_en && sd_respond) begin
                sd_addr = bus.rd_sec_addr;
                repeat (2) @(negedge clk_ref);
                bus.rd_busy = 1'b1;
                @(negedge clk_ref);
                for (int i = 0; i < sd_words; i++) begin
                    bus.rd_val_en   = 1'b1;
                    bus.rd_val_data = {sd_addr[7:0], 8'(i)};
                    if (i == sd_words - 1) bus.rd_busy = 1'b0;
                    @(negedge clk_ref);
                end
                bus.rd_val_en = 1'b0;
                bus.rd_busy   = 1'b0;
            end
        end
    end

    // Monitor: counts requests, writes, done pulses; checks each FIFO word against its sector/index.
    int          n_req = 0, n_wr = 0, n_done = 0, data_bad = 0, widx = 0;
    logic [31:0] cur_addr = '0;
    logic [31:0] addr_log[$];
    always @(negedge clk_ref) begin
        if (bus.rd_start_en) begin
            addr_log.push_back(bus.rd_sec_addr);
            cur_addr = bus.rd_sec_addr;
            widx = 0;
            n_req++;
        end
        if (bus.fifo_wr_en) begin
            if (bus.fifo_wr_data !== {cur_addr[7:0], 8'(widx)}) data_bad++;
            widx++;
            n_wr++;
        end
        if (done) n_done++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] base;
        logic [15:0] num;
        int          words;
        int          exp_req;
        int          exp_wr;
        int          exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;
    vec_t vt[6];

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk_ref); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_ref);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int r0, w0, d0, a0, b0, k;
        bit ok;
        logic [31:0] ea;

        vt[0] = '{32'h0000_1000, 16'd3, 256, 3, 768, 1, 1'b0, ERR_NONE};
        vt[1] = '{32'hFFFF_FFFE, 16'd3, 256, 3, 768, 1, 1'b0, ERR_NONE};
        vt[2] = '{32'h0000_0055, 16'd2, 255, 1, 255, 0, 1'b1, ERR_CNT};
        vt[3] = '{32'h0000_0077, 16'd2, 257, 1, 257, 0, 1'b1, ERR_CNT};
        vt[4] = '{32'h0000_0099, 16'd0, 256, 0, 0,   0, 1'b1, ERR_ZERO};
        vt[5] = '{32'h0000_0020, 16'd1, 256, 1, 256, 1, 1'b0, ERR_NONE};

        sd_init_done = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        base_sec = '0; num_secs = '0; bus.fifo_free = 16'd1024;
        sd_respond = 1'b1; sd_words = 256;

        repeat (3) @(posedge clk_ref); #1;
        chk("reset_ctl", {busy, done, err, err_code, sec_idx, bus.rd_start_en, bus.fifo_wr_en}, '0);
        chk("reset_bus", {bus.rd_sec_addr, bus.fifo_wr_data}, '0);
        rst = 1'b0;
        @(posedge clk_ref); #1;

        for (int v = 0; v < 6; v++) begin
            r0 = n_req; w0 = n_wr; d0 = n_done; a0 = addr_log.size(); b0 = data_bad;
            sd_words = vt[v].words;
            base_sec = vt[v].base;
            num_secs = vt[v].num;
            pulse_start();
            wait_idle(4000, ok);
            chk($sformatf("v%0d_idle", v), ok, 1);
            repeat (5) @(posedge clk_ref); #1;
            chk($sformatf("v%0d_req", v), n_req - r0, vt[v].exp_req);
            chk($sformatf("v%0d_wr", v), n_wr - w0, vt[v].exp_wr);
            chk($sformatf("v%0d_done", v), n_done - d0, vt[v].exp_done);
            chk($sformatf("v%0d_err", v), err, vt[v].exp_err);
            chk($sformatf("v%0d_code", v), err_code, vt[v].exp_code);
            chk($sformatf("v%0d_data", v), data_bad - b0, 0);
            for (int i = 0; i < vt[v].exp_req && a0 + i < addr_log.size(); i++) begin
                ea = vt[v].base + 32'(i);
                chk($sformatf("v%0d_addr%0d", v, i), addr_log[a0 + i], ea);
            end
        end

        // Init and room gating: nothing is issued until the card is ready and a full sector fits.
        r0 = n_req; w0 = n_wr; d0 = n_done; a0 = addr_log.size();
        sd_words = 256; sd_init_done = 1'b0; bus.fifo_free = 16'd200;
        base_sec = 32'h300; num_secs = 16'd1;
        pulse_start();
        repeat (20) @(posedge clk_ref); #1;
        chk("init_hold_req", n_req - r0, 0);
        chk("init_hold_busy", busy, 1);
        sd_init_done = 1'b1;
        repeat (50) @(posedge clk_ref); #1;
        chk("room_hold_req", n_req - r0, 0);
        bus.fifo_free = 16'd256;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_ref);
            if (bus.rd_start_en) begin
                k = i;
                break;
            end
        end
        chk("room_issue_lat", (k >= 1 && k <= 2), 1);
        wait_idle(2000, ok);
        chk("room_idle", ok, 1);
        repeat (3) @(posedge clk_ref); #1;
        chk("room_wr", n_wr - w0, 256);
        chk("room_done", n_done - d0, 1);
        chk("room_addr", addr_log[a0], 32'h300);
        bus.fifo_free = 16'd1024;

        // Timeout: card never raises rd_busy.
        r0 = n_req;
        sd_respond = 1'b0;
        base_sec = 32'h400; num_secs = 16'd1;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_ref);
            if (bus.rd_start_en) begin
                ok = 1'b1;
                break;
            end
        end
        chk("to_issue", ok, 1);
        k = 0;
        for (int i = 1; i <= TO_C + 20; i++) begin
            @(negedge clk_ref);
            if (err) begin
                k = i;
                break;
            end
        end
        chk("to_latency", k, TO_C + 1);
        chk("to_code", err_code, ERR_TO);
        chk("to_busy", busy, 0);
        repeat (30) @(posedge clk_ref); #1;
        chk("to_no_reissue", n_req - r0, 1);
        sd_respond = 1'b1;

        // Looping run across the 32-bit address wrap, aborted during the third sector.
        r0 = n_req; w0 = n_wr; d0 = n_done; a0 = addr_log.size(); b0 = data_bad;
        loop_en = 1'b1; base_sec = 32'hFFFF_FFFF; num_secs = 16'd2;
        pulse_start();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_ref);
            if (n_req - r0 >= 3) break;
        end
        chk("loop_3rd_req", n_req - r0, 3);
        chk("loop_idx_reset", sec_idx, 0);
        repeat (50) @(posedge clk_ref); #1;
        abort = 1'b1;
        @(posedge clk_ref); #1;
        abort = 1'b0;
        wait_idle(2000, ok);
        chk("loop_idle", ok, 1);
        repeat (300) @(posedge clk_ref); #1;
        chk("loop_req", n_req - r0, 3);
        chk("loop_wr", n_wr - w0, 768);
        chk("loop_done", n_done - d0, 1);
        chk("loop_err", err, 0);
        chk("loop_data", data_bad - b0, 0);
        chk("loop_addr0", addr_log[a0], 32'hFFFF_FFFF);
        chk("loop_addr1", addr_log[a0 + 1], 32'h0000_0000);
        chk("loop_addr2", addr_log[a0 + 2], 32'hFFFF_FFFF);
        loop_en = 1'b0;

        // Reset in the middle of a sector.
        base_sec = 32'h900; num_secs = 16'd2;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_ref);
            if (bus.fifo_wr_en) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_mid_xfer_seen", ok, 1);
        @(posedge clk_ref); #1;
        rst = 1'b1;
        @(negedge clk_ref);
        chk("rst_mid_ctl", {busy, done, err, err_code, sec_idx, bus.rd_start_en, bus.fifo_wr_en}, '0);
        chk("rst_mid_bus", {bus.rd_sec_addr, bus.fifo_wr_data}, '0);
        r0 = n_req; w0 = n_wr;
        @(posedge clk_ref); #1;
        rst = 1'b0;
        repeat (400) @(posedge clk_ref); #1;
        chk("rst_no_wr", n_wr - w0, 0);
        chk("rst_no_req", n_req - r0, 0);
        chk("rst_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
